// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register with a two-entry skid buffer.
// Ready is registered, so there is no combinational path from out_ready to in_ready.
module mem_wb_skid_reg #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     mem_data_in,
   input  logic [DATA_WIDTH-1:0]     alu_result_in,
   input  logic [REG_ADDR_WIDTH-1:0] reg_dest_in,
   input  logic                      MemToReg_in,
   input  logic                      RegWrite_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     mem_data_out,
   output logic [DATA_WIDTH-1:0]     alu_result_out,
   output logic [REG_ADDR_WIDTH-1:0] reg_dest_out,
   output logic                      MemToReg_out,
   output logic                      RegWrite_out,
   output logic [DATA_WIDTH-1:0]     wb_data_out
);

   localparam int EW = 2 * DATA_WIDTH + REG_ADDR_WIDTH + 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [EW-1:0]           main_q, main_d;
   logic [EW-1:0]           skid_q, skid_d;
   logic [EW-1:0]           in_entry_s;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;
   logic                    regwrite_q, regwrite_d;
   logic [DATA_WIDTH-1:0]   wb_data_q, wb_data_d;
   logic                    accept_s, pop_s;

   // Entry layout: {mem_data, alu_result, reg_dest, MemToReg, RegWrite}
   assign in_entry_s = {mem_data_in, alu_result_in, reg_dest_in, MemToReg_in, RegWrite_in};
   assign accept_s   = in_valid & in_ready_q;
   assign pop_s      = out_valid_q & out_ready;

   // Occupancy next-state and entry movement between input, skid and main
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept_s) begin
                  state_d = ONE;
                  main_d  = in_entry_s;
               end else begin
                  state_d = EMPTY;
               end
            end
            ONE: begin
               if (accept_s && !pop_s) begin
                  state_d = FULL;
                  skid_d  = in_entry_s;
               end else if (accept_s && pop_s) begin
                  state_d = ONE;
                  main_d  = in_entry_s;
               end else if (pop_s) begin
                  state_d = EMPTY;
               end else begin
                  state_d = ONE;
               end
            end
            FULL: begin
               if (pop_s) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end else begin
                  state_d = FULL;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   // Output-side values precomputed from the next head entry so every output is a flop
   always_comb begin
      out_valid_d = (state_d != EMPTY);
      in_ready_d  = (state_d != FULL);
      if (main_d[1]) begin
         wb_data_d = main_d[EW-1 -: DATA_WIDTH];
      end else begin
         wb_data_d = main_d[EW-DATA_WIDTH-1 -: DATA_WIDTH];
      end
      regwrite_d = main_d[0] & out_valid_d &
                   (main_d[REG_ADDR_WIDTH+1:2] != {REG_ADDR_WIDTH{1'b0}});
   end

   // State and storage registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= EMPTY;
         main_q      <= {EW{1'b0}};
         skid_q      <= {EW{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         regwrite_q  <= 1'b0;
         wb_data_q   <= {DATA_WIDTH{1'b0}};
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         regwrite_q  <= regwrite_d;
         wb_data_q   <= wb_data_d;
      end
   end

   assign in_ready       = in_ready_q;
   assign out_valid      = out_valid_q;
   assign mem_data_out   = main_q[EW-1 -: DATA_WIDTH];
   assign alu_result_out = main_q[EW-DATA_WIDTH-1 -: DATA_WIDTH];
   assign reg_dest_out   = main_q[REG_ADDR_WIDTH+1:2];
   assign MemToReg_out   = main_q[1];
   assign RegWrite_out   = regwrite_q;
   assign wb_data_out    = wb_data_q;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Scoreboard bench for mem_wb_skid_reg: directed scenarios plus randomized traffic,
// checked against a queue model with a capacity of two entries.
module tb_mem_wb_skid_reg;

   localparam int DW  = 32;
   localparam int RAW = 5;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic            flush = 1'b0;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b0;
   logic [DW-1:0]   mem_i = '0;
   logic [DW-1:0]   alu_i = '0;
   logic [RAW-1:0]  dest_i = '0;
   logic            m2r_i = 1'b0;
   logic            rw_i = 1'b0;

   logic            in_ready, out_valid, MemToReg_out, RegWrite_out;
   logic [DW-1:0]   mem_data_out, alu_result_out, wb_data_out;
   logic [RAW-1:0]  reg_dest_out;

   mem_wb_skid_reg #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .mem_data_in   (mem_i),
      .alu_result_in (alu_i),
      .reg_dest_in   (dest_i),
      .MemToReg_in   (m2r_i),
      .RegWrite_in   (rw_i),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .mem_data_out  (mem_data_out),
      .alu_result_out(alu_result_out),
      .reg_dest_out  (reg_dest_out),
      .MemToReg_out  (MemToReg_out),
      .RegWrite_out  (RegWrite_out),
      .wb_data_out   (wb_data_out)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [DW-1:0]  mem;
      logic [DW-1:0]  alu;
      logic [RAW-1:0] dest;
      logic           m2r;
      logic           rw;
   } ent_t;

   ent_t sb[$];
   int   tests = 0;
   int   fails = 0;
   logic last_flush = 1'b0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO of capacity two; flush empties it and drops the incoming entry
   bit   m_acc, m_pop;
   ent_t m_e;
   always begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
         sb.delete();
         last_flush = 1'b0;
      end else begin
         m_acc = in_valid && (sb.size() < 2);
         m_pop = out_ready && (sb.size() > 0);
         last_flush = flush;
         if (flush) begin
            sb.delete();
         end else begin
            if (m_pop) void'(sb.pop_front());
            if (m_acc) begin
               m_e = '{mem: mem_i, alu: alu_i, dest: dest_i, m2r: m2r_i, rw: rw_i};
               sb.push_back(m_e);
            end
         end
      end
   end

   // Monitor: compare DUT outputs with the model head on every falling edge
   ent_t           h;
   logic           prev_hold = 1'b0;
   logic [DW-1:0]  prev_mem, prev_alu, prev_wb;
   logic [RAW-1:0] prev_dest;
   always @(negedge clock) begin
      if (!reset_n) begin
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_in_ready", 32'(in_ready), 32'd1);
         chk("rst_regwrite", 32'(RegWrite_out), 32'd0);
         chk("rst_wb_data", wb_data_out, 32'd0);
         prev_hold = 1'b0;
      end else begin
         chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
         chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
         if (sb.size() > 0) begin
            h = sb[0];
            chk("mem_data", mem_data_out, h.mem);
            chk("alu_result", alu_result_out, h.alu);
            chk("reg_dest", 32'(reg_dest_out), 32'(h.dest));
            chk("memtoreg", 32'(MemToReg_out), 32'(h.m2r));
            chk("wb_data", wb_data_out, h.m2r ? h.mem : h.alu);
            chk("regwrite", 32'(RegWrite_out), 32'(h.rw && (h.dest != 5'd0)));
            if (prev_hold && !last_flush) begin
               chk("stall_mem", mem_data_out, prev_mem);
               chk("stall_alu", alu_result_out, prev_alu);
               chk("stall_wb", wb_data_out, prev_wb);
               chk("stall_dest", 32'(reg_dest_out), 32'(prev_dest));
            end
         end else begin
            chk("regwrite_idle", 32'(RegWrite_out), 32'd0);
         end
         prev_hold = out_valid && !out_ready;
         prev_mem  = mem_data_out;
         prev_alu  = alu_result_out;
         prev_wb   = wb_data_out;
         prev_dest = reg_dest_out;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [DW-1:0] m, input logic [DW-1:0] a,
                         input logic [RAW-1:0] d, input logic mt, input logic rw);
      in_valid = v;
      mem_i    = m;
      alu_i    = a;
      dest_i   = d;
      m2r_i    = mt;
      rw_i     = rw;
   endtask

   int p_in, p_out;

   initial begin
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);

      // Single entry latency after reset
      out_ready = 1'b1;
      set_in(1'b1, 32'h0, 32'h11, 5'd3, 1'b0, 1'b1);
      step();
      set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      chk("lat_out_valid", 32'(out_valid), 32'd1);
      chk("lat_wb_data", wb_data_out, 32'h11);
      chk("lat_regwrite", 32'(RegWrite_out), 32'd1);
      chk("lat_dest", 32'(reg_dest_out), 32'd3);
      step();
      chk("lat_drained", 32'(out_valid), 32'd0);

      // Backpressure: fill both entries, then drain in order
      out_ready = 1'b0;
      set_in(1'b1, 32'h0, 32'hA, 5'd1, 1'b0, 1'b1);
      step();
      set_in(1'b1, 32'h0, 32'hB, 5'd2, 1'b0, 1'b1);
      step();
      set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      chk("bp_full_in_ready", 32'(in_ready), 32'd0);
      chk("bp_head_a", alu_result_out, 32'hA);
      step();
      chk("bp_hold_a", alu_result_out, 32'hA);
      out_ready = 1'b1;
      step();
      chk("bp_head_b", alu_result_out, 32'hB);
      chk("bp_ready_again", 32'(in_ready), 32'd1);
      step();
      chk("bp_empty", 32'(out_valid), 32'd0);

      // Continuous stream: every cycle must present the just-accepted value
      for (int i = 1; i <= 32; i++) begin
         set_in(1'b1, 32'h0, 32'(i), 5'd4, 1'b0, 1'b1);
         step();
         chk("stream_valid", 32'(out_valid), 32'd1);
         chk("stream_value", alu_result_out, 32'(i));
      end
      set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      step();
      chk("stream_end", 32'(out_valid), 32'd0);

      // Load to register 0: data selected from memory, write suppressed
      out_ready = 1'b0;
      set_in(1'b1, 32'hDEAD, 32'hBEEF, 5'd0, 1'b1, 1'b1);
      step();
      set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      chk("r0_wb_data", wb_data_out, 32'hDEAD);
      chk("r0_regwrite", 32'(RegWrite_out), 32'd0);
      out_ready = 1'b1;
      step();

      // Flush while full with a simultaneous incoming entry
      out_ready = 1'b0;
      set_in(1'b1, 32'h0, 32'h21, 5'd5, 1'b0, 1'b1);
      step();
      set_in(1'b1, 32'h0, 32'h22, 5'd6, 1'b0, 1'b1);
      step();
      flush = 1'b1;
      set_in(1'b1, 32'h0, 32'h23, 5'd7, 1'b0, 1'b1);
      step();
      flush = 1'b0;
      set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      step();
      step();
      chk("flush_nothing_left", 32'(out_valid), 32'd0);

      // Randomized traffic with varying rates, occasional flush and one mid-run reset
      for (int i = 0; i < 10000; i++) begin
         if (i % 1000 == 0) begin
            p_in  = 20 + int'($urandom_range(0, 80));
            p_out = 20 + int'($urandom_range(0, 80));
         end
         if (i == 5000) reset_n = 1'b0;
         if (i == 5002) reset_n = 1'b1;
         flush     = ($urandom_range(0, 199) == 0);
         out_ready = (int'($urandom_range(0, 99)) < p_out);
         set_in(int'($urandom_range(0, 99)) < p_in, $urandom(), $urandom(),
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom()),
                1'($urandom()), 1'($urandom()));
         step();
      end
      flush = 1'b0;
      set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("final_empty", 32'(out_valid), 32'd0);
      chk("final_model_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_wb_skid_reg.md
MEM_WB_SKID_REG -- requirements
Module: mem_wb_skid_reg

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of mem_data and alu_result paths.
REQ-002 Parameter REG_ADDR_WIDTH, 5, width of destination register index.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous discard of all held entries.
REQ-006 in_valid  input  1  upstream (MEM) entry present.
REQ-007 in_ready  output  1  block can accept an entry this cycle.
REQ-008 mem_data_in  input  DATA_WIDTH  load data from memory stage.
REQ-009 alu_result_in  input  DATA_WIDTH  ALU result from memory stage.
REQ-010 reg_dest_in  input  REG_ADDR_WIDTH  destination register index.
REQ-011 MemToReg_in, RegWrite_in  input  1 each  write-back control.
REQ-012 out_valid  output  1  head entry present.
REQ-013 out_ready  input  1  downstream (WB) consumes head entry.
REQ-014 mem_data_out, alu_result_out  output  DATA_WIDTH  head entry data.
REQ-015 reg_dest_out  output  REG_ADDR_WIDTH  head entry destination.
REQ-016 MemToReg_out  output  1  head entry MemToReg.
REQ-017 RegWrite_out  output  1  qualified register-file write enable.
REQ-018 wb_data_out  output  DATA_WIDTH  selected write-back value.

Function
REQ-019 Storage SHALL be two entries: main (head, drives outputs) and skid; each with a valid bit.
REQ-020 accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-021 in_ready SHALL be registered and equal to NOT skid_valid; no combinational path from out_ready to in_ready.
REQ-022 out_valid SHALL equal main_valid.
REQ-023 States: EMPTY (none valid), ONE (main only), FULL (main+skid).
REQ-024 EMPTY: accept -> ONE, main loaded; pop impossible.
REQ-025 ONE: accept & !pop -> FULL, skid loaded; accept & pop -> ONE, main loaded with new entry; !accept & pop -> EMPTY; neither -> hold.
REQ-026 FULL: in_ready=0; pop -> ONE, main loaded from skid, skid invalidated; else hold.
REQ-027 Entries SHALL leave in arrival order; no entry dropped or duplicated except by flush/reset.
REQ-028 Latency: entry accepted at edge N appears at outputs (out_valid=1) after edge N when EMPTY; zero bubbles under continuous in_valid/out_ready.
REQ-029 Held output fields SHALL remain stable while out_valid=1 and out_ready=0.
REQ-030 wb_data_out = mem_data_out when MemToReg_out=1, else alu_result_out.
REQ-031 RegWrite_out = main RegWrite & out_valid & (reg_dest_out != 0); writes to register 0 suppressed.
REQ-032 flush=1 at an edge SHALL clear both valid bits and drop any simultaneous accept; flush has priority over accept and pop; in_ready=1 after that edge.
REQ-033 Data fields of invalid entries are don't-care except as fixed by reset.

Reset
REQ-034 reset_n=0 SHALL immediately clear main_valid, skid_valid, all data/control registers to 0; in_ready=1, out_valid=0, RegWrite_out=0, wb_data_out=0.
REQ-035 Reset asserted mid-transfer SHALL discard all entries; first accept after release lands in EMPTY state.

Verification
REQ-036 Reset then in_valid=1 {alu=0x11, dest=3, RegWrite=1, MemToReg=0}, out_ready=1 -> next cycle out_valid=1, wb_data_out=0x11, RegWrite_out=1, reg_dest_out=3.
REQ-037 out_ready=0, push A=0xA then B=0xB -> in_ready=0 after second edge, outputs hold A; raise out_ready -> A, then B, then out_valid=0; in_ready=1 one cycle after first pop.
REQ-038 Continuous stream 0x1..0x20 with out_ready=1 -> 32 consecutive out_valid cycles, values in order, no bubbles.
REQ-039 Entry {mem=0xDEAD, alu=0xBEEF, MemToReg=1, dest=0, RegWrite=1} -> wb_data_out=0xDEAD, RegWrite_out=0.
REQ-040 FULL with flush=1 and in_valid=1 same cycle -> next cycle out_valid=0, in_ready=1, flushed and incoming entries never appear.
REQ-041 Random in_valid/out_ready 10k cycles vs. scoreboard queue -> exact order match, depth never exceeds 2, held outputs stable under stall.
